// File: rtl/pixel_pkg.sv
// pixel_pkg: shared pixel type, colour slice positions and sink FSM states.
package pixel_pkg;
  typedef logic [31:0] pixel_t;
  localparam int R_HI = 31;
  localparam int R_LO = 24;
  localparam int G_HI = 23;
  localparam int G_LO = 16;
  typedef enum logic {WAIT_SOF, ACTIVE} sink_state_e;
endpackage

// File: rtl/axis_pixel_counter.sv
// axis_pixel_counter: x/y raster counters; restart treats the current beat as pixel (0,0).
module axis_pixel_counter #(
  parameter int WIDTH = 20,
  parameter int HEIGHT = 20,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          restart,
  output logic [XW-1:0] px,
  output logic [YW-1:0] py,
  output logic          at_origin,
  output logic          eol,
  output logic          eof
);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  assign at_origin = x == '0 && y == '0;
  assign px = restart ? '0 : x;
  assign py = restart ? '0 : y;
  assign eol = px == XW'(WIDTH - 1);
  assign eof = eol && py == YW'(HEIGHT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      x <= eol ? '0 : px + 1'b1;
      y <= eof ? '0 : eol ? py + 1'b1 : py;
    end
  end
endmodule

// File: rtl/axis_pixel_sink.sv
// axis_pixel_sink: AXI-Stream pixel stream to framebuffer writes with SOF/EOL checking.
// Define AXIS_PIXEL_SINK_CHECKSUM_EN to enable the per-frame data checksum.
module axis_pixel_sink import pixel_pkg::*; #(
  parameter int WIDTH = 20,
  parameter int HEIGHT = 20,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  pixel_t        s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tuser,
  input  logic          s_axis_tlast,
  output logic          fb_we,
  input  logic          fb_ready,
  output logic [AW-1:0] fb_addr,
  output pixel_t        fb_data,
  output logic [XW-1:0] fb_x,
  output logic [YW-1:0] fb_y,
  output logic          frame_done,
  output logic          err_sof,
  output logic          err_eol,
  output logic          err_sticky,
  output logic [31:0]   frame_checksum
);
  sink_state_e state, state_nx;
  logic accept, sof, write, bad_sof, bad_eol;
  logic at_origin, eol, eof;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  assign s_axis_tready = !fb_we || fb_ready;
  axis_pixel_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_cnt (
    .clk(clk), .rst(rst), .step(write), .restart(sof),
    .px(px), .py(py), .at_origin(at_origin), .eol(eol), .eof(eof)
  );
  always_comb begin
    accept = s_axis_tvalid && s_axis_tready;
    sof = accept && s_axis_tuser;
    write = accept && (state == ACTIVE || s_axis_tuser);
    bad_sof = sof && state == ACTIVE && !at_origin;
    bad_eol = write && (s_axis_tlast != eol);
    state_nx = write ? (eof ? WAIT_SOF : ACTIVE) : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_SOF;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      fb_x <= '0;
      fb_y <= '0;
      frame_done <= 1'b0;
      err_sof <= 1'b0;
      err_eol <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_nx;
      if (write) begin
        fb_we <= 1'b1;
        fb_addr <= AW'(py) * AW'(WIDTH) + AW'(px);
        fb_data <= s_axis_tdata;
        fb_x <= px;
        fb_y <= py;
      end else if (fb_ready) begin
        fb_we <= 1'b0;
      end
      frame_done <= write && eof;
      err_sof <= bad_sof;
      err_eol <= bad_eol;
      err_sticky <= err_sticky || bad_sof || bad_eol;
    end
  end
`ifdef AXIS_PIXEL_SINK_CHECKSUM_EN
  logic [31:0] acc, acc_nx;
  assign acc_nx = (sof ? 32'd0 : acc) + s_axis_tdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      frame_checksum <= '0;
    end else if (write) begin
      acc <= acc_nx;
      if (eof) frame_checksum <= acc_nx;
    end
  end
`else
  assign frame_checksum = '0;
`endif
endmodule
